// File: rtl/dac_pattern_pkg.sv
// Shared types and PRBS15 constants for the DAC test-pattern generator.
// PRBS lanes exist only when DAC_PATTERN_PRBS_EN is defined.
package dac_pattern_pkg;

    typedef enum logic [2:0] {
        MODE_ZERO  = 3'd0,
        MODE_CONST = 3'd1,
        MODE_RAMP  = 3'd2,
        MODE_PRBS  = 3'd3,
        MODE_BURST = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP
    } state_e;

    localparam int          PRBS_W      = 15;
    localparam logic [14:0] PRBS_SEED   = 15'h7FFF;
    localparam int          PRBS_TAP_HI = 14;
    localparam int          PRBS_TAP_LO = 13;

    // x^15 + x^14 + 1, Fibonacci form, shifting towards the MSB
    function automatic logic [14:0] prbs15_next(input logic [14:0] s);
        return {s[13:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
    endfunction

    function automatic mode_e decode_mode(input logic [2:0] m);
        mode_e r;
        case (m)
            3'd1:    r = MODE_CONST;
            3'd2:    r = MODE_RAMP;
            3'd3:    r = MODE_PRBS;
            3'd4:    r = MODE_BURST;
            default: r = MODE_ZERO;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dac_pattern_lfsr.sv
// One PRBS15 lane; reseeded on load, advanced once per step.
// Instantiated by the generator only under DAC_PATTERN_PRBS_EN.
module dac_pattern_lfsr
    import dac_pattern_pkg::*;
#(
    parameter logic [14:0] RST_SEED = PRBS_SEED
) (
    input  logic        clk,
    input  logic        rstf,
    input  logic [14:0] i_seed,
    input  logic        i_load,
    input  logic        i_step,
    output logic [14:0] o_state
);

    logic [14:0] state_q;

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            state_q <= RST_SEED;
        end else if (i_load) begin
            state_q <= i_seed;
        end else if (i_step) begin
            state_q <= prbs15_next(state_q);
        end
    end

    assign o_state = state_q;

endmodule

// File: rtl/dac_pattern_generator.sv
// Multi-lane valid/ready test-pattern source for the DAC datapath.
// Define DAC_PATTERN_PRBS_EN to build the PRBS15 lanes (mode 3).
module dac_pattern_generator
    import dac_pattern_pkg::*;
#(
    parameter int LANE_W    = 16,
    parameter int LANES     = 2,
    parameter int BURST_LEN = 64,
    parameter int GAP_LEN   = 16,
    parameter int CNT_W     = 32
) (
    input  logic                    clk,
    input  logic                    rstf,
    input  logic                    i_enable,
    input  logic [2:0]              i_mode,
    input  logic [LANE_W-1:0]       i_const,
    input  logic [LANE_W-1:0]       i_step,
    output logic [LANES*LANE_W-1:0] o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [CNT_W-1:0]        o_count,
    output logic                    o_busy
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    state_e            state_q;
    mode_e             mode_q;
    logic [LANE_W-1:0] const_q;
    logic [LANE_W-1:0] step_q;
    logic [LANE_W-1:0] acc_q;
    logic [CNT_W-1:0]  count_q;
    logic              valid_q;
    logic [BW-1:0]     burst_q;
    logic [GW-1:0]     gap_q;

    logic xfer;
    logic start;
    logic burst_last;
    logic gap_last;
    logic [LANES*LANE_W-1:0] pat;

    assign xfer       = valid_q && i_ready;
    assign start      = (state_q == ST_IDLE) && i_enable;
    assign burst_last = (burst_q == BW'(BURST_LEN - 1));
    assign gap_last   = (gap_q == GW'(GAP_LEN - 1));

`ifdef DAC_PATTERN_PRBS_EN
    logic [14:0] lfsr_state [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_lfsr
        localparam logic [14:0] SEED = PRBS_SEED ^ 15'(k + 1);
        dac_pattern_lfsr #(
            .RST_SEED (SEED)
        ) u_lfsr (
            .clk     (clk),
            .rstf    (rstf),
            .i_seed  (SEED),
            .i_load  (start),
            .i_step  (xfer),
            .o_state (lfsr_state[k])
        );
    end
`endif

    always_comb begin
        pat = '0;
        for (int k = 0; k < LANES; k++) begin
            case (mode_q)
                MODE_CONST:
                    pat[k*LANE_W +: LANE_W] = const_q;
                MODE_RAMP, MODE_BURST:
                    pat[k*LANE_W +: LANE_W] = acc_q + LANE_W'(k) * step_q;
`ifdef DAC_PATTERN_PRBS_EN
                MODE_PRBS:
                    pat[k*LANE_W +: LANE_W] = LANE_W'(lfsr_state[k]);
`endif
                default:
                    pat[k*LANE_W +: LANE_W] = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_ZERO;
            const_q <= '0;
            step_q  <= '0;
            acc_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            burst_q <= '0;
            gap_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_enable) begin
                        state_q <= ST_RUN;
                        mode_q  <= decode_mode(i_mode);
                        const_q <= i_const;
                        step_q  <= i_step;
                        acc_q   <= '0;
                        count_q <= '0;
                        burst_q <= '0;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        acc_q   <= acc_q + step_q * LANE_W'(LANES);
                        count_q <= count_q + CNT_W'(1);
                        if (mode_q == MODE_BURST) begin
                            burst_q <= burst_last ? '0 : burst_q + BW'(1);
                        end
                        if (!i_enable) begin
                            valid_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end else if (mode_q == MODE_BURST && burst_last) begin
                            valid_q <= 1'b0;
                            gap_q   <= '0;
                            state_q <= ST_GAP;
                        end
                    end else if (!valid_q) begin
                        if (i_enable) begin
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (!i_enable) begin
                        state_q <= ST_IDLE;
                    end else if (gap_last) begin
                        // raise valid directly so the gap is exactly GAP_LEN cycles
                        valid_q <= 1'b1;
                        burst_q <= '0;
                        state_q <= ST_RUN;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_data  = valid_q ? pat : '0;
    assign o_valid = valid_q;
    assign o_count = count_q;
    assign o_busy  = (state_q != ST_IDLE);

endmodule
